line_burst_adapter: RTL and testbench

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

---
 rtl/line_burst_if.sv | 67 ++++++
 rtl/line_burst_adapter.sv | 143 ++++++++++++++
 tb/tb_line_burst_adapter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_if.sv
// ----------------------------------------------------------------------------
// line_burst_if
// Groups the two buses that meet at the line/burst adapter:
//   pmem_*  : cache-side line interface (one full line per transaction)
//   burst_* : memory-side burst interface (one beat per accepted burst_resp)
//
// Modports
//   slave  : the adapter. It responds on pmem_* and drives requests on burst_*.
//   master : the environment, meaning the cache plus the memory. It drives
//            pmem_* requests and burst_* responses.
//
// Parameters
//   s_line : line width in bits
//   s_beat : beat width in bits
// ----------------------------------------------------------------------------
interface line_burst_if #(
  parameter int s_line = 256,
  parameter int s_beat = 64
);

  // cache side
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  // memory side
  logic              burst_read;
  logic              burst_write;
  logic [31:0]       burst_address;
  logic [s_beat-1:0] burst_wdata;
  logic [s_beat-1:0] burst_rdata;
  logic              burst_resp;

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_rdata,
    output pmem_resp,
    output burst_read,
    output burst_write,
    output burst_address,
    output burst_wdata,
    input  burst_rdata,
    input  burst_resp
  );

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_rdata,
    input  pmem_resp,
    input  burst_read,
    input  burst_write,
    input  burst_address,
    input  burst_wdata,
    output burst_rdata,
    output burst_resp
  );

endinterface

// File: rtl/line_burst_adapter.sv
// ----------------------------------------------------------------------------
// line_burst_adapter
// Serves the cache's line-wide pmem_* requests by splitting each line into a
// burst of s_line/s_beat beats on the memory side. Only one transaction is
// ever in flight. A write takes priority over a read requested in the same
// cycle, and the read is picked up on a later IDLE cycle.
//
// Ports
//   clk : single clock. All state changes on the rising edge.
//   rst : asynchronous, active-high reset. It abandons any burst in progress.
//   bus : line_burst_if.slave
//         pmem_read / pmem_write  : line requests, sampled only in IDLE
//         pmem_address            : line address, low s_offset bits ignored
//         pmem_wdata / pmem_rdata : line to write / last line read
//         pmem_resp               : one-cycle completion pulse
//         burst_read / write      : high for the whole burst
//         burst_address           : line-aligned address of the burst
//         burst_wdata             : write beat selected by the beat counter
//         burst_rdata             : read beat from memory
//         burst_resp              : beat accepted (write) or beat valid (read)
//
// Parameters
//   s_offset : log2 of line size in bytes
//   s_line   : line width in bits
//   s_beat   : beat width in bits
// ----------------------------------------------------------------------------
module line_burst_adapter #(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_beat   = 64
) (
  input  logic         clk,
  input  logic         rst,
  line_burst_if.slave  bus
);

  localparam int beats = s_line / s_beat;
  localparam int kw    = (beats > 1) ? $clog2(beats) : 1;

  localparam logic [kw-1:0] last_beat  = kw'(beats - 1);
  // Masking, rather than slicing off the low bits, keeps every address bit
  // in use.
  localparam logic [31:0]   align_mask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    RBURST,
    WBURST,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [kw-1:0]     k_q, k_d;
  logic [31:0]       addr_q, addr_d;
  logic [s_line-1:0] wdata_q, wdata_d;
  logic [s_line-1:0] line_q, line_d;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here is given its hold value first. A path
    // that does not assign a signal would otherwise infer a latch.
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;

    unique case (state_q)
      IDLE: begin
        // Write wins when both requests are present. burst_resp is ignored.
        if (bus.pmem_write) begin
          addr_d  = bus.pmem_address & align_mask;
          wdata_d = bus.pmem_wdata;
          k_d     = '0;
          state_d = WBURST;
        end else if (bus.pmem_read) begin
          addr_d  = bus.pmem_address & align_mask;
          k_d     = '0;
          state_d = RBURST;
        end
      end

      RBURST: begin
        if (bus.burst_resp) begin
          line_d[int'(k_q)*s_beat +: s_beat] = bus.burst_rdata;
          if (k_q == last_beat) state_d = RESP;
          else                  k_d     = k_q + 1'b1;
        end
      end

      WBURST: begin
        if (bus.burst_resp) begin
          if (k_q == last_beat) state_d = RESP;
          else                  k_d     = k_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      // NOTE: the line buffer is a plain register, not a RAM, so clearing it
      // is cheap. Clearing it also makes pmem_rdata read zero straight out of
      // reset.
      line_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments. Every flop samples its _d value from
      // before this edge, whatever order the statements are written in.
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. They are decoded straight from registers, so an async reset
  // clears them with no clock edge needed.
  // --------------------------------------------------------------------------
  assign bus.burst_read    = (state_q == RBURST);
  assign bus.burst_write   = (state_q == WBURST);
  assign bus.pmem_resp     = (state_q == RESP);
  assign bus.burst_address = addr_q;
  assign bus.burst_wdata   = wdata_q[int'(k_q)*s_beat +: s_beat];
  assign bus.pmem_rdata    = line_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// ----------------------------------------------------------------------------
// tb_line_burst_adapter
// Directed bench for line_burst_adapter. A table of line transactions is
// replayed through one driver task. A few hand-written sequences follow:
// simultaneous requests, a spurious burst_resp while idle, and a reset in
// the middle of a burst.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_line_burst_adapter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  line_burst_if #(.s_line(256), .s_beat(64)) bus ();

  line_burst_adapter #(
    .s_offset(5),
    .s_line  (256),
    .s_beat  (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic         wr;
    logic         rd;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;  // hand-aligned burst address
    logic [255:0] line;      // wdata for writes, returned beats for reads
    int           stall;     // idle cycles before each accepted beat
  } txn_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [255:0] exp_rdata;   // expected contents of pmem_rdata
  txn_t         tbl [5];

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge while the adapter is IDLE. Returns at the
  // falling edge of the IDLE cycle that follows RESP. When hold_rd is set,
  // pmem_read stays high after pmem_resp.
  task automatic run_txn(input txn_t t, input logic hold_rd);
    logic exp_br;
    logic exp_bw;
    exp_bw = t.wr;
    exp_br = !t.wr;
    bus.pmem_write   = t.wr;
    bus.pmem_read    = t.rd;
    bus.pmem_address = t.addr;
    bus.pmem_wdata   = t.line;
    bus.burst_resp   = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s <= t.stall; s++) begin
        check("burst_read", {255'd0, bus.burst_read}, {255'd0, exp_br});
        check("burst_write", {255'd0, bus.burst_write}, {255'd0, exp_bw});
        check("burst_address", {224'd0, bus.burst_address}, {224'd0, t.exp_addr});
        check("pmem_resp_early", {255'd0, bus.pmem_resp}, 256'd0);
        if (t.wr) check("burst_wdata", {192'd0, bus.burst_wdata},
                        {192'd0, t.line[b*64 +: 64]});
        bus.burst_resp  = (s == t.stall);
        // During stall cycles the data bus carries junk that must not land
        // in the line buffer.
        bus.burst_rdata = (s == t.stall) ? t.line[b*64 +: 64]
                                         : ~t.line[b*64 +: 64];
        @(negedge clk);
      end
    end
    bus.burst_resp = 1'b0;
    if (!t.wr) exp_rdata = t.line;
    check("pmem_resp", {255'd0, bus.pmem_resp}, 256'd1);
    check("resp_burst_read", {255'd0, bus.burst_read}, 256'd0);
    check("resp_burst_write", {255'd0, bus.burst_write}, 256'd0);
    bus.pmem_write = 1'b0;
    if (!hold_rd) bus.pmem_read = 1'b0;
    @(negedge clk);
    check("pmem_resp_single", {255'd0, bus.pmem_resp}, 256'd0);
    check("idle_burst_read", {255'd0, bus.burst_read}, 256'd0);
    check("idle_burst_write", {255'd0, bus.burst_write}, 256'd0);
    check("pmem_rdata", bus.pmem_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_1234, 32'h0000_1220,
               {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_5678, 32'h0000_5660,
               {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 2};
    tbl[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0}, 1};
    tbl[3] = '{1'b1, 1'b0, 32'h8000_001F, 32'h8000_0000,
               {64'h1357_9BDF_0246_8ACE, 64'h5555_AAAA_5555_AAAA,
                64'h0000_0000_FFFF_FFFF, 64'hCAFE_F00D_DEAD_BEEF}, 0};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0020,
               {64'h8888_7777_6666_5555, 64'h0000_0000_0000_0001,
                64'h8000_0000_0000_0000, 64'h1234_1234_1234_1234}, 3};

    // ---------------- reset state ----------------
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_pmem_resp", {255'd0, bus.pmem_resp}, 256'd0);
    check("rst_burst_read", {255'd0, bus.burst_read}, 256'd0);
    check("rst_burst_write", {255'd0, bus.burst_write}, 256'd0);
    check("rst_burst_address", {224'd0, bus.burst_address}, 256'd0);
    check("rst_burst_wdata", {192'd0, bus.burst_wdata}, 256'd0);
    check("rst_pmem_rdata", bus.pmem_rdata, 256'd0);
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // ---------------- table of transactions ----------------
    for (int i = 0; i < 5; i++) run_txn(tbl[i], 1'b0);

    // ------- simultaneous read+write: write first, then the held read -------
    t = '{1'b1, 1'b1, 32'h0000_0A4C, 32'h0000_0A40,
          {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
           64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A}, 0};
    run_txn(t, 1'b1);
    t = '{1'b0, 1'b1, 32'h0000_0A4C, 32'h0000_0A40,
          {64'h9999_0000_9999_0000, 64'h7777_0000_7777_0000,
           64'h5555_0000_5555_0000, 64'h3333_0000_3333_0000}, 0};
    run_txn(t, 1'b0);

    // ---------------- spurious burst_resp in IDLE ----------------
    bus.burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    bus.burst_resp  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("spur_burst_read", {255'd0, bus.burst_read}, 256'd0);
      check("spur_burst_write", {255'd0, bus.burst_write}, 256'd0);
      check("spur_pmem_resp", {255'd0, bus.pmem_resp}, 256'd0);
      check("spur_pmem_rdata", bus.pmem_rdata, exp_rdata);
    end
    bus.burst_resp = 1'b0;
    @(negedge clk);

    // ---------------- reset after beat 2 of a read ----------------
    bus.pmem_read    = 1'b1;
    bus.pmem_address = 32'h0000_4047;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = 64'h6666_6666_6666_6666;
      @(negedge clk);
    end
    bus.burst_resp = 1'b0;
    check("mid_burst_read", {255'd0, bus.burst_read}, 256'd1);
    check("mid_burst_address", {224'd0, bus.burst_address}, {224'd0, 32'h0000_4040});
    rst = 1'b1;
    #1;
    check("arst_burst_read", {255'd0, bus.burst_read}, 256'd0);
    check("arst_burst_write", {255'd0, bus.burst_write}, 256'd0);
    check("arst_pmem_resp", {255'd0, bus.pmem_resp}, 256'd0);
    check("arst_burst_address", {224'd0, bus.burst_address}, 256'd0);
    check("arst_burst_wdata", {192'd0, bus.burst_wdata}, 256'd0);
    check("arst_pmem_rdata", bus.pmem_rdata, 256'd0);
    exp_rdata = '0;
    bus.pmem_read = 1'b0;
    @(negedge clk);
    check("rst_hold_pmem_resp", {255'd0, bus.pmem_resp}, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_pmem_resp", {255'd0, bus.pmem_resp}, 256'd0);
    check("post_rst_burst_read", {255'd0, bus.burst_read}, 256'd0);
    t = '{1'b0, 1'b1, 32'h0000_4047, 32'h0000_4040,
          {64'hA1A1_B2B2_C3C3_D4D4, 64'hE5E5_F6F6_0707_1818,
           64'h2929_3A3A_4B4B_5C5C, 64'h6D6D_7E7E_8F8F_9090}, 0};
    run_txn(t, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
